// File: rtl/apple_iie_bus_initiator.sv
// Apple IIe bus-cycle initiator: derives Phi0/Q3/PRAS_n from the 14M clock and runs queued requests as bus cycles.
// Optional APPLE_IIE_LONG_CYCLE_EN: every 65th bus cycle is stretched to 16 ticks.
module apple_iie_bus_initiator (
    input  logic        clk_14m,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_addr,
    input  logic        req_rw_n,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        clk_phi_0,
    output logic        clk_q3,
    output logic        pras_n,
    output logic [15:0] a,
    output logic        rw_n,
    output logic [7:0]  d_out,
    output logic        d_oe,
    input  logic [7:0]  d_in,
    input  logic        md7
);

    // state | meaning
    // IDLE  | parked cycle: a = FFFF, read strobe, bus not driven
    // ACTIVE| executing the request accepted at the previous cycle's last tick
    typedef enum logic {S_IDLE = 1'b0, S_ACTIVE = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [3:0]  tick_q, tick_d;
    logic [3:0]  l_cur, l_next;
    logic        last_tick, accept;

    logic        phi0_q, phi0_d;
    logic        q3_q, q3_d;
    logic        pras_n_q, pras_n_d;
    logic        ready_q, ready_d;
    logic [15:0] a_q, a_d;
    logic        rw_n_q, rw_n_d;
    logic [7:0]  d_out_q, d_out_d;
    logic        d_oe_q, d_oe_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [7:0]  rsp_rdata_q, rsp_rdata_d;

`ifdef APPLE_IIE_LONG_CYCLE_EN
    logic [6:0]  cyc_q, cyc_d;
`endif

    always_ff @(posedge clk_14m) begin
        if (reset) begin
            state_q     <= S_IDLE;
            tick_q      <= 4'd0;
            phi0_q      <= 1'b0;
            q3_q        <= 1'b1;
            pras_n_q    <= 1'b1;
            ready_q     <= 1'b0;
            a_q         <= 16'hFFFF;
            rw_n_q      <= 1'b1;
            d_out_q     <= 8'h00;
            d_oe_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'h00;
`ifdef APPLE_IIE_LONG_CYCLE_EN
            cyc_q       <= 7'd0;
`endif
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            phi0_q      <= phi0_d;
            q3_q        <= q3_d;
            pras_n_q    <= pras_n_d;
            ready_q     <= ready_d;
            a_q         <= a_d;
            rw_n_q      <= rw_n_d;
            d_out_q     <= d_out_d;
            d_oe_q      <= d_oe_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
`ifdef APPLE_IIE_LONG_CYCLE_EN
            cyc_q       <= cyc_d;
`endif
        end
    end

    always_comb begin
        last_tick = (tick_q == l_cur);
        accept    = req_valid & ready_q;
        tick_d    = last_tick ? 4'd0 : tick_q + 4'd1;
        state_d   = state_q;
        if (last_tick) begin
            state_d = accept ? S_ACTIVE : S_IDLE;
        end
`ifdef APPLE_IIE_LONG_CYCLE_EN
        cyc_d = cyc_q;
        if (last_tick) begin
            cyc_d = (cyc_q == 7'd64) ? 7'd0 : cyc_q + 7'd1;
        end
        l_cur  = (cyc_q == 7'd64) ? 4'd15 : 4'd13;
        l_next = (cyc_d == 7'd64) ? 4'd15 : 4'd13;
`else
        l_cur  = 4'd13;
        l_next = 4'd13;
`endif
    end

    // Every output is computed from the tick it will be visible in, so all of them come straight from flops.
    always_comb begin
        phi0_d   = (tick_d >= 4'd7);
        q3_d     = (tick_d <= 4'd3) || ((tick_d >= 4'd7) && (tick_d <= 4'd10));
        pras_n_d = !(((tick_d >= 4'd4) && (tick_d <= 4'd6)) || (tick_d >= 4'd11));
        ready_d  = (tick_d == l_next);

        a_d     = a_q;
        rw_n_d  = rw_n_q;
        d_out_d = d_out_q;
        if (last_tick) begin
            if (accept) begin
                a_d     = req_addr;
                rw_n_d  = req_rw_n;
                d_out_d = req_rw_n ? 8'h00 : req_wdata;
            end else begin
                a_d     = 16'hFFFF;
                rw_n_d  = 1'b1;
                d_out_d = 8'h00;
            end
        end
        d_oe_d = (state_d == S_ACTIVE) && !rw_n_d && (tick_d >= 4'd7);

        rsp_valid_d = last_tick && (state_q == S_ACTIVE);
        rsp_rdata_d = rsp_rdata_q;
        if (last_tick && (state_q == S_ACTIVE)) begin
            if (!rw_n_q) begin
                rsp_rdata_d = 8'h00;
            end else if (a_q[15:4] == 12'hC01) begin
                rsp_rdata_d = {md7, d_in[6:0]};
            end else begin
                rsp_rdata_d = d_in;
            end
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign clk_phi_0 = phi0_q;
    assign clk_q3    = q3_q;
    assign pras_n    = pras_n_q;
    assign a         = a_q;
    assign rw_n      = rw_n_q;
    assign d_out     = d_out_q;
    assign d_oe      = d_oe_q;

endmodule

// File: tb/tb_apple_iie_bus_initiator.sv
// Directed bench for apple_iie_bus_initiator: vector table of single requests plus back-to-back and mid-cycle reset sequences.
module tb_apple_iie_bus_initiator;

    logic        clk_14m = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_addr = 16'h0000;
    logic        req_rw_n = 1'b1;
    logic [7:0]  req_wdata = 8'h00;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        clk_phi_0, clk_q3, pras_n;
    logic [15:0] a;
    logic        rw_n;
    logic [7:0]  d_out;
    logic        d_oe;
    logic [7:0]  d_in = 8'h00;
    logic        md7 = 1'b0;

    int total = 0;
    int bad = 0;

    always #35 clk_14m = ~clk_14m;

    apple_iie_bus_initiator dut (
        .clk_14m(clk_14m), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_rw_n(req_rw_n), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .clk_phi_0(clk_phi_0), .clk_q3(clk_q3), .pras_n(pras_n),
        .a(a), .rw_n(rw_n), .d_out(d_out), .d_oe(d_oe),
        .d_in(d_in), .md7(md7)
    );

    typedef struct {
        logic [15:0] addr;
        logic        rw_n;
        logic [7:0]  wdata;
        logic [7:0]  din;
        logic        md7;
        logic [7:0]  exp_rdata;
    } vec_t;

    vec_t vecs[5];
    vec_t b2b[3];

    // Per-tick patterns, bit n = value during tick n.
    logic [13:0] phi0_pat = 14'b11111110000000;
    logic [13:0] q3_pat   = 14'b00011110001111;
    logic [13:0] pras_pat = 14'b00011110001111;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_14m);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL wait_ready: req_ready got 0 within 40 ticks want 1");
        end
    endtask

    task automatic drive_req(input vec_t v);
        req_valid = 1'b1;
        req_addr  = v.addr;
        req_rw_n  = v.rw_n;
        req_wdata = v.wdata;
    endtask

    initial begin
        #(70 * 20000);
        $display("FAIL watchdog: simulation got stuck want finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        int n;
        int phi_cnt;
        int seen;

        vecs[0] = '{16'hC013, 1'b1, 8'h00, 8'h5A, 1'b1, 8'hDA};
        vecs[1] = '{16'h0300, 1'b1, 8'h00, 8'h5A, 1'b1, 8'h5A};
        vecs[2] = '{16'hC005, 1'b0, 8'hAB, 8'h5A, 1'b1, 8'h00};
        vecs[3] = '{16'hC01F, 1'b1, 8'h00, 8'h80, 1'b0, 8'h00};
        vecs[4] = '{16'hC020, 1'b1, 8'h00, 8'h7F, 1'b1, 8'h7F};
        b2b[0]  = '{16'hC080, 1'b1, 8'h00, 8'h33, 1'b1, 8'h33};
        b2b[1]  = '{16'h0400, 1'b0, 8'h5C, 8'hEE, 1'b0, 8'h00};
        b2b[2]  = '{16'hD000, 1'b1, 8'h00, 8'h81, 1'b0, 8'h81};

        // Reset values after three reset ticks
        repeat (3) @(negedge clk_14m);
        chk("rst_phi0", clk_phi_0, 1'b0);
        chk("rst_q3", clk_q3, 1'b1);
        chk("rst_pras", pras_n, 1'b1);
        chk("rst_a", a, 16'hFFFF);
        chk("rst_rw_n", rw_n, 1'b1);
        chk("rst_d_out", d_out, 8'h00);
        chk("rst_d_oe", d_oe, 1'b0);
        chk("rst_ready", req_ready, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_rdata", rsp_rdata, 8'h00);
        reset = 1'b0;

        // Idle parking and clock waveforms over two cycles
        for (int i = 1; i <= 28; i++) begin
            @(negedge clk_14m);
            chk("park_a", a, 16'hFFFF);
            chk("park_phi0", clk_phi_0, phi0_pat[i % 14]);
            chk("park_q3", clk_q3, q3_pat[i % 14]);
            chk("park_pras", pras_n, pras_pat[i % 14]);
            chk("park_ready", req_ready, (i % 14) == 13);
            chk("park_rsp_valid", rsp_valid, 1'b0);
        end

        // Single requests from the vector table
        for (int v = 0; v < 5; v++) begin
            wait_ready(ok);
            if (!ok) continue;
            drive_req(vecs[v]);
            d_in = vecs[v].din;
            md7  = vecs[v].md7;
            for (int t = 0; t <= 13; t++) begin
                @(negedge clk_14m);
                if (t == 0) begin
                    chk("vec_rsp_idle", rsp_valid, 1'b0);
                    req_valid = 1'b0;
                    req_addr  = 16'h1234;
                    req_rw_n  = ~vecs[v].rw_n;
                    req_wdata = 8'h99;
                end
                chk("vec_a", a, vecs[v].addr);
                chk("vec_rw_n", rw_n, vecs[v].rw_n);
                chk("vec_d_oe", d_oe, !vecs[v].rw_n && (t >= 7));
                chk("vec_ready", req_ready, t == 13);
                chk("vec_phi0", clk_phi_0, phi0_pat[t]);
                if (!vecs[v].rw_n) chk("vec_d_out", d_out, vecs[v].wdata);
            end
            @(negedge clk_14m);
            chk("vec_rsp_valid", rsp_valid, 1'b1);
            chk("vec_rsp_rdata", rsp_rdata, vecs[v].exp_rdata);
            chk("vec_park_after", a, 16'hFFFF);
            chk("vec_d_oe_after", d_oe, 1'b0);
            @(negedge clk_14m);
            chk("vec_rsp_pulse", rsp_valid, 1'b0);
            chk("vec_rsp_hold", rsp_rdata, vecs[v].exp_rdata);
        end

        // Back-to-back requests with req_valid held
        wait_ready(ok);
        if (ok) begin
            drive_req(b2b[0]);
            for (int r = 0; r < 3; r++) begin
                for (int t = 0; t <= 13; t++) begin
                    @(negedge clk_14m);
                    if (t == 0) begin
                        chk("b2b_rsp_valid", rsp_valid, r > 0);
                        if (r > 0) chk("b2b_rsp_rdata", rsp_rdata, b2b[r-1].exp_rdata);
                        d_in = b2b[r].din;
                        md7  = b2b[r].md7;
                    end
                    chk("b2b_a", a, b2b[r].addr);
                    chk("b2b_rw_n", rw_n, b2b[r].rw_n);
                    chk("b2b_d_oe", d_oe, !b2b[r].rw_n && (t >= 7));
                    chk("b2b_ready", req_ready, t == 13);
                    if (t == 13) begin
                        if (r < 2) drive_req(b2b[r+1]);
                        else req_valid = 1'b0;
                    end
                end
            end
            @(negedge clk_14m);
            chk("b2b_last_rsp", rsp_valid, 1'b1);
            chk("b2b_last_rdata", rsp_rdata, b2b[2].exp_rdata);
            chk("b2b_park", a, 16'hFFFF);
        end

        // Reset at tick 9 of a write abandons it
        wait_ready(ok);
        if (ok) begin
            drive_req('{16'h0200, 1'b0, 8'h77, 8'h00, 1'b0, 8'h00});
            for (int t = 0; t <= 9; t++) begin
                @(negedge clk_14m);
                if (t == 0) req_valid = 1'b0;
            end
            chk("mid_d_oe_t9", d_oe, 1'b1);
            reset = 1'b1;
            @(negedge clk_14m);
            chk("mid_d_oe", d_oe, 1'b0);
            chk("mid_rw_n", rw_n, 1'b1);
            chk("mid_a", a, 16'hFFFF);
            chk("mid_ready", req_ready, 1'b0);
            @(negedge clk_14m);
            reset = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk_14m);
                chk("mid_no_rsp", rsp_valid, 1'b0);
                chk("mid_parked", a, 16'hFFFF);
            end
        end

`ifdef APPLE_IIE_LONG_CYCLE_EN
        // Stretched cycle: 65 cycles span 912 ticks, cycle 64 samples at tick 15
        reset = 1'b1;
        repeat (2) @(negedge clk_14m);
        reset = 1'b0;
        n = 0;
        seen = 0;
        phi_cnt = 0;
        while (seen < 64 && n < 1000) begin
            @(negedge clk_14m);
            n++;
            if (req_ready) seen++;
        end
        chk("long_64th_ready", n, 16'd895);
        drive_req('{16'h0300, 1'b1, 8'h00, 8'h00, 1'b0, 8'h00});
        d_in = 8'h11;
        for (int t = 0; t <= 15; t++) begin
            @(negedge clk_14m);
            n++;
            if (t == 0) req_valid = 1'b0;
            if (t == 15) d_in = 8'h3C;
            phi_cnt += int'(clk_phi_0);
            chk("long_ready", req_ready, t == 15);
        end
        chk("long_912", n, 16'd911);
        chk("long_phi0_high", phi_cnt, 16'd9);
        @(negedge clk_14m);
        chk("long_rsp_valid", rsp_valid, 1'b1);
        chk("long_rsp_rdata", rsp_rdata, 8'h3C);
`else
        n = 0;
        seen = 0;
        phi_cnt = 0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
